// File: rtl/sun_pll_ctrl.sv
// SUN_PLL power-up sequencer and lock detector: brings up bias, oscillator/divider
// and charge pump in order, then tracks lock from the synchronised PFD error.
module sun_pll_ctrl #(
    parameter int BIAS_CYCLES  = 64,
    parameter int START_CYCLES = 16,
    parameter int LOCK_CYCLES  = 256,
    parameter int UNLOCK_ERRS  = 4,
    parameter int ACQ_TIMEOUT  = 4096,
    parameter int CNT_W        = 13
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       EN,
    input  logic       PHASE_ERR,
    output logic       PWRUP_BIAS,
    output logic       PWRUP_OSC,
    output logic       CP_EN,
    output logic       LOCK,
    output logic       TIMEOUT,
    output logic [3:0] RETRIES,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        BIAS_WAIT = 3'd1,
        OSC_START = 3'd2,
        ACQUIRE   = 3'd3,
        LOCKED    = 3'd4,
        RETRY     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] BIAS_LAST  = CNT_W'(BIAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNL_LAST   = CNT_W'(UNLOCK_ERRS - 1);
    localparam logic [CNT_W-1:0] ACQ_LAST   = CNT_W'(ACQ_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, gcnt_q, gcnt_d, ecnt_q, ecnt_d;
    logic             sync_q, err_s_q;
    logic             timeout_q, timeout_d;
    logic [3:0]       retries_q, retries_d;
    logic             bias_q, bias_d, osc_q, osc_d, cp_q, cp_d, lock_q, lock_d;

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        retries_d = retries_q;
        gcnt_d    = gcnt_q;
        ecnt_d    = ecnt_q;
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (!EN) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF: begin
                    state_d   = BIAS_WAIT;
                    timeout_d = 1'b0;
                    retries_d = 4'd0;
                end
                BIAS_WAIT: if (cnt_q == BIAS_LAST)  state_d = OSC_START;
                OSC_START: if (cnt_q == START_LAST) state_d = ACQUIRE;
                RETRY:     if (cnt_q == START_LAST) state_d = OSC_START;
                ACQUIRE: begin
                    if (err_s_q)                  gcnt_d  = '0;
                    else if (gcnt_q >= LOCK_LAST) state_d = LOCKED;
                    else                          gcnt_d  = gcnt_q + CNT_W'(1);
                    // Lock takes priority over a coincident timeout.
                    if (state_d == ACQUIRE && cnt_q >= ACQ_LAST) begin
                        state_d   = RETRY;
                        timeout_d = 1'b1;
                        retries_d = (retries_q == 4'd15) ? retries_q : retries_q + 4'd1;
                    end
                end
                LOCKED: begin
                    if (!err_s_q)                ecnt_d  = '0;
                    else if (ecnt_q >= UNL_LAST) state_d = ACQUIRE;
                    else                         ecnt_d  = ecnt_q + CNT_W'(1);
                end
                default: state_d = OFF;
            endcase
        end
        if (state_d != state_q) begin
            cnt_d  = '0;
            gcnt_d = '0;
            ecnt_d = '0;
        end
        bias_d = state_d inside {BIAS_WAIT, OSC_START, ACQUIRE, LOCKED, RETRY};
        osc_d  = state_d inside {OSC_START, ACQUIRE, LOCKED};
        cp_d   = state_d inside {ACQUIRE, LOCKED};
        lock_d = (state_d == LOCKED);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q   <= OFF;
            cnt_q     <= '0;
            gcnt_q    <= '0;
            ecnt_q    <= '0;
            sync_q    <= 1'b1;
            err_s_q   <= 1'b1;
            timeout_q <= 1'b0;
            retries_q <= 4'd0;
            bias_q    <= 1'b0;
            osc_q     <= 1'b0;
            cp_q      <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gcnt_q    <= gcnt_d;
            ecnt_q    <= ecnt_d;
            sync_q    <= PHASE_ERR;
            err_s_q   <= sync_q;
            timeout_q <= timeout_d;
            retries_q <= retries_d;
            bias_q    <= bias_d;
            osc_q     <= osc_d;
            cp_q      <= cp_d;
            lock_q    <= lock_d;
        end
    end

    assign PWRUP_BIAS = bias_q;
    assign PWRUP_OSC  = osc_q;
    assign CP_EN      = cp_q;
    assign LOCK       = lock_q;
    assign TIMEOUT    = timeout_q;
    assign RETRIES    = retries_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_sun_pll_ctrl.sv
// Bench for sun_pll_ctrl: directed scenarios plus random error bursts, every cycle
// compared against a phase/run-length model of the sequencer.
module tb_sun_pll_ctrl;
    localparam int BIAS = 64, START = 16, LOCKC = 256, UNL = 4, ACQ = 4096;

    logic       CK = 1'b0, RN = 1'b0, EN = 1'b0, PHASE_ERR = 1'b0;
    logic       PWRUP_BIAS, PWRUP_OSC, CP_EN, LOCK, TIMEOUT;
    logic [3:0] RETRIES;
    logic [2:0] STATE;

    int errors = 0, checks = 0;

    // model: phase, cycles spent in phase, clean/error run lengths, flags, sync pipe
    int m_ph, m_t, m_good, m_bad, m_to, m_rt;
    bit m_s1, m_es;

    sun_pll_ctrl dut (
        .CK(CK), .RN(RN), .EN(EN), .PHASE_ERR(PHASE_ERR),
        .PWRUP_BIAS(PWRUP_BIAS), .PWRUP_OSC(PWRUP_OSC), .CP_EN(CP_EN), .LOCK(LOCK),
        .TIMEOUT(TIMEOUT), .RETRIES(RETRIES), .STATE(STATE)
    );

    always #5 CK = ~CK;

    function automatic logic [11:0] dut_out();
        return {PWRUP_BIAS, PWRUP_OSC, CP_EN, LOCK, TIMEOUT, RETRIES, STATE};
    endfunction

    function automatic logic [11:0] model_out();
        logic b, o, c, l;
        b = m_ph inside {1, 2, 3, 4, 5};
        o = m_ph inside {2, 3, 4};
        c = m_ph inside {3, 4};
        l = (m_ph == 4);
        return {b, o, c, l, m_to != 0, 4'(m_rt), 3'(m_ph)};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, {11'b0, obs}, {11'b0, exp});
    endtask

    task automatic model_reset();
        m_ph = 0; m_t = 0; m_good = 0; m_bad = 0; m_to = 0; m_rt = 0;
        m_s1 = 1'b1; m_es = 1'b1;
    endtask

    task automatic model_step(input logic en, input logic pin);
        bit e;
        int np;
        e = m_es; m_es = m_s1; m_s1 = pin;
        np = m_ph;
        if (!en) np = 0;
        else case (m_ph)
            0: begin np = 1; m_to = 0; m_rt = 0; end
            1: if (m_t == BIAS - 1) np = 2;
            2: if (m_t == START - 1) np = 3;
            5: if (m_t == START - 1) np = 2;
            3: begin
                m_good = e ? 0 : m_good + 1;
                if (m_good >= LOCKC) np = 4;
                else if (m_t == ACQ - 1) begin
                    np = 5; m_to = 1; m_rt = (m_rt < 15) ? m_rt + 1 : 15;
                end
            end
            4: begin
                m_bad = e ? m_bad + 1 : 0;
                if (m_bad >= UNL) np = 3;
            end
            default: np = 0;
        endcase
        if (np != m_ph) begin
            m_ph = np; m_t = 0; m_good = 0; m_bad = 0;
        end else m_t++;
    endtask

    task automatic step(input logic en, input logic pe);
        EN = en; PHASE_ERR = pe;
        @(posedge CK);
        model_step(en, pe);
        #1 check("cycle", dut_out(), model_out());
    endtask

    // Fixed edge numbers of the bring-up sequence, counted from the first enable edge.
    task automatic seq_chk(input int i);
        if (i == 1)   chk1("bias_e1", PWRUP_BIAS, 1'b1);
        if (i == 64)  chk1("osc_e64", PWRUP_OSC, 1'b0);
        if (i == 65)  chk1("osc_e65", PWRUP_OSC, 1'b1);
        if (i == 80)  chk1("cp_e80", CP_EN, 1'b0);
        if (i == 81)  chk1("cp_e81", CP_EN, 1'b1);
        if (i == 336) chk1("lock_e336", LOCK, 1'b0);
        if (i == 337) begin
            chk1("lock_e337", LOCK, 1'b1);
            check("flags_e337", {7'b0, TIMEOUT, RETRIES}, 12'h0);
        end
    endtask

    initial begin
        bit lock_seen;
        int guard;
        model_reset();
        #12;
        check("reset_out", dut_out(), 12'h0);
        RN = 1'b1;

        // 1: clean bring-up
        for (int i = 1; i <= 340; i++) begin
            step(1'b1, 1'b0);
            seq_chk(i);
        end

        // 2: constant phase error -> repeated timeouts, saturating retry count
        lock_seen = 1'b0;
        for (int c = 0; c < 16 * (ACQ + 2 * START) + 50; c++) begin
            step(1'b1, 1'b1);
            if (c > 10 && LOCK) lock_seen = 1'b1;
        end
        chk1("no_lock_err", lock_seen, 1'b0);
        chk1("timeout_set", TIMEOUT, 1'b1);
        check("retries_sat", {8'b0, RETRIES}, 12'd15);

        // 6: drop EN during OSC_START for 3 cycles
        guard = 0;
        while (m_ph != 2 && guard < 5000) begin step(1'b1, 1'b1); guard++; end
        chk1("reach_osc", guard < 5000, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        check("off_state", {9'b0, STATE}, 12'd0);
        check("off_hold", {7'b0, TIMEOUT, RETRIES}, {7'b0, 1'b1, 4'd15});
        for (int i = 1; i <= 340; i++) begin
            step(1'b1, 1'b0);
            seq_chk(i);
        end

        // 3: short pulse tolerated, 4-cycle pulse unlocks 6 edges after start
        repeat (3) step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        chk1("lock_keep3", LOCK, 1'b1);
        for (int e = 1; e <= 300; e++) begin
            step(1'b1, e <= 4);
            if (e == 5)   chk1("lock_e5", LOCK, 1'b1);
            if (e == 6)   chk1("lock_drop_e6", LOCK, 1'b0);
            if (e == 261) chk1("relock_e261", LOCK, 1'b0);
            if (e == 262) chk1("relock_e262", LOCK, 1'b1);
        end

        // 4: unlock again, glitch seen at gcnt=200 restarts the clean run
        for (int e = 1; e <= 470; e++) begin
            step(1'b1, (e <= 4) || (e == 205));
            if (e == 462) chk1("glitch_e462", LOCK, 1'b0);
            if (e == 463) chk1("glitch_e463", LOCK, 1'b1);
        end

        // 5: asynchronous reset while locked
        #2 RN = 1'b0;
        #1 check("async_rst", dut_out(), 12'h0);
        model_reset();
        @(posedge CK);
        #1 check("rst_held", dut_out(), 12'h0);
        RN = 1'b1;
        for (int i = 1; i <= 340; i++) begin
            step(1'b1, 1'b0);
            seq_chk(i);
        end

        // random clean runs, error bursts and occasional EN drops
        for (int s = 0; s < 24; s++) begin
            int len, blen;
            len  = $urandom_range(1, 400);
            blen = $urandom_range(1, 6);
            repeat (len) step(1'b1, 1'b0);
            repeat (blen) step(1'b1, 1'b1);
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) step(1'b0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sun_pll_ctrl.md
Name: sun_pll_ctrl

Overview:
Power-up sequencer and lock detector for the SUN_PLL analog core. It brings up the bias, then the ring oscillator and feedback divider, then the charge pump, in a fixed order with fixed settle times. It then declares lock from the PFD phase-error indication and retries acquisition on timeout. It runs on the reference clock and drives the analog enables through level shifting outside this block.

Parameters:
BIAS_CYCLES, 64, CK cycles from bias enable to oscillator/divider enable
START_CYCLES, 16, CK cycles from oscillator enable to charge-pump enable; also the retry off-time
LOCK_CYCLES, 256, consecutive clean samples required to declare lock
UNLOCK_ERRS, 4, consecutive error samples in LOCKED that drop lock
ACQ_TIMEOUT, 4096, max CK cycles in ACQUIRE before a retry
CNT_W, 13, width of the shared cycle counter; must hold ACQ_TIMEOUT

Ports:
CK  input  1  reference clock (CK_REF domain)
RN  input  1  asynchronous active-low reset
EN  input  1  PLL enable, synchronous to CK
PHASE_ERR  input  1  asynchronous; high while CP_UP or CP_DOWN is pulsing wide
PWRUP_BIAS  output  1  bias block enable
PWRUP_OSC  output  1  ROSC and DIVN enable (PWRUP_1V8)
CP_EN  output  1  charge-pump enable
LOCK  output  1  PLL locked
TIMEOUT  output  1  sticky flag: at least one acquisition timeout since enable
RETRIES  output  4  saturating count of acquisition retries
STATE  output  3  current FSM state encoding, for debug

Behaviour:
- Clock and reset: one clock, CK. Reset RN is asynchronous and active-low. While RN=0, every output is 0, FSM=OFF and all counters are 0.
- Synchronisation: PHASE_ERR passes through a 2-flop synchroniser whose flops are reset to 1, giving err_s. err_s lags the pin by 2 cycles. Only err_s is used.
- Registered outputs: all outputs are registered and decoded from the next state, so each output changes on the same edge as the state transition.
- State encoding and outputs:
  - OFF=0: all enables 0.
  - BIAS_WAIT=1: PWRUP_BIAS=1.
  - OSC_START=2: PWRUP_BIAS=1, PWRUP_OSC=1.
  - ACQUIRE=3: PWRUP_BIAS=1, PWRUP_OSC=1, CP_EN=1.
  - LOCKED=4: as ACQUIRE, plus LOCK=1.
  - RETRY=5: PWRUP_BIAS=1 only.
- Counter: a single counter cnt is cleared on every state entry.
- Transitions:
  - OFF -> BIAS_WAIT when EN=1. This transition also clears TIMEOUT and RETRIES.
  - BIAS_WAIT -> OSC_START when cnt==BIAS_CYCLES-1. PWRUP_OSC therefore rises exactly BIAS_CYCLES edges after PWRUP_BIAS.
  - OSC_START -> ACQUIRE when cnt==START_CYCLES-1.
  - ACQUIRE: good counter gcnt increments on err_s=0 and clears on err_s=1.
    - -> LOCKED when gcnt reaches LOCK_CYCLES-1 with err_s=0.
    - -> RETRY when cnt==ACQ_TIMEOUT-1 and no lock: TIMEOUT<=1, RETRIES saturates at 15.
    - If the lock and timeout conditions hit in the same cycle, LOCKED wins.
  - RETRY -> OSC_START when cnt==START_CYCLES-1.
  - LOCKED: ecnt increments on err_s=1 and clears on err_s=0.
    - -> ACQUIRE (LOCK falls) when ecnt reaches UNLOCK_ERRS-1 with err_s=1.
    - gcnt is cleared on that transition.
- EN=0 in any state: -> OFF on the next edge. TIMEOUT and RETRIES hold their values until the next enable.
- EN re-asserted while in OFF: the sequence restarts from BIAS_WAIT. There is no shortcut.
- RN asserted mid-sequence: all enables drop immediately, without waiting for a clock edge.
- Counter widths: cnt, gcnt and ecnt never wrap. Each saturates at its threshold. Parameters must be ≥1.
- Illegal STATE encodings (6, 7): -> OFF on the next edge.

Test Plan:
1. Reset then EN=1, PHASE_ERR=0 -> PWRUP_BIAS at edge 1, PWRUP_OSC at edge 65, CP_EN at edge 81, LOCK at edge 81+256=337. TIMEOUT=0, RETRIES=0.
2. PHASE_ERR=1 held, EN=1 -> LOCK never rises. After 4096 cycles in ACQUIRE: TIMEOUT=1, RETRIES=1, PWRUP_OSC=0 for 16 cycles, then back to OSC_START. After 16 further timeouts RETRIES stays at 15.
3. Locked, then a 3-cycle PHASE_ERR pulse -> LOCK stays 1. A 4-cycle pulse -> LOCK falls 2+4 edges after pulse start. A clean stretch afterwards re-locks after 256 more cycles.
4. ACQUIRE with an error glitch at gcnt=200 -> gcnt resets, and LOCK arrives 256 cycles after the glitch's synchronised sample.
5. RN pulsed low while in LOCKED -> all outputs 0 asynchronously, STATE=0. On release with EN=1 the sequence restarts from BIAS_WAIT with the timing of scenario 1.
6. EN dropped during OSC_START, re-raised 3 cycles later -> OFF for those cycles, full sequence repeats. TIMEOUT and RETRIES are cleared on re-entry.
